// File: rtl/w5500_block_assembler.sv
// Packs the W5500 receive byte stream into 128-bit cipher blocks, PKCS#7-pads on flush,
// and double-buffers (assembly + output register), dropping and flagging bytes on overflow.
module w5500_block_assembler #(
  parameter int DATA_WIDTH  = 8,
  parameter int BLOCK_BYTES = 16
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic [DATA_WIDTH-1:0]             i_data_in,
  input  logic                              i_data_valid,
  input  logic                              i_flush,
  output logic [BLOCK_BYTES*DATA_WIDTH-1:0] o_block,
  output logic                              o_block_valid,
  input  logic                              i_block_ready,
  output logic [4:0]                        o_byte_count,
  output logic                              o_overflow
);

  localparam int         LP_W    = BLOCK_BYTES * DATA_WIDTH;
  localparam logic [4:0] LP_FULL = 5'(BLOCK_BYTES);

  logic [LP_W-1:0]       r_asm;
  logic [4:0]            r_cnt;
  logic [LP_W-1:0]       r_out;
  logic                  r_valid;
  logic                  r_flush_pend;
  logic                  r_overflow;

  logic                  w_accept;
  logic                  w_drop;
  logic [4:0]            w_cnt_post;
  logic [LP_W-1:0]       w_asm_acc;
  logic [DATA_WIDTH-1:0] w_pad_val;
  logic [LP_W-1:0]       w_out_next;
  logic                  w_out_free;
  logic                  w_flush_req;
  logic                  w_transfer;
  logic                  w_full_post;

  always_comb begin
    w_accept    = i_data_valid && (r_cnt < LP_FULL);
    w_drop      = i_data_valid && (r_cnt == LP_FULL);
    w_cnt_post  = r_cnt + 5'(w_accept);
    w_full_post = (w_cnt_post == LP_FULL);
    w_out_free  = !r_valid || i_block_ready;
    w_flush_req = r_flush_pend || i_flush;
    w_transfer  = w_out_free && (w_full_post || w_flush_req);
    w_pad_val   = DATA_WIDTH'(LP_FULL - w_cnt_post);

    w_asm_acc = r_asm;
    for (int unsigned i = 0; i < BLOCK_BYTES; i++) begin
      if (w_accept && (i == 32'(r_cnt)))
        w_asm_acc[(BLOCK_BYTES-1-i)*DATA_WIDTH +: DATA_WIDTH] = i_data_in;
    end

    // Slots at or beyond the post-accept count take the pad value; a full block has none.
    w_out_next = '0;
    for (int unsigned i = 0; i < BLOCK_BYTES; i++) begin
      if (i < 32'(w_cnt_post))
        w_out_next[(BLOCK_BYTES-1-i)*DATA_WIDTH +: DATA_WIDTH] =
          w_asm_acc[(BLOCK_BYTES-1-i)*DATA_WIDTH +: DATA_WIDTH];
      else
        w_out_next[(BLOCK_BYTES-1-i)*DATA_WIDTH +: DATA_WIDTH] = w_pad_val;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_asm        <= '0;
      r_cnt        <= '0;
      r_out        <= '0;
      r_valid      <= 1'b0;
      r_flush_pend <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_asm <= w_asm_acc;
      if (w_drop)
        r_overflow <= 1'b1;
      if (w_transfer) begin
        r_out   <= w_out_next;
        r_valid <= 1'b1;
        r_cnt   <= '0;
        // An aligned flush ships the data block now and keeps the flush for a 0x10 pad block.
        r_flush_pend <= w_full_post && w_flush_req;
      end else begin
        r_cnt <= w_cnt_post;
        if (r_valid && i_block_ready)
          r_valid <= 1'b0;
        if (i_flush)
          r_flush_pend <= 1'b1;
      end
    end
  end

  assign o_block       = r_out;
  assign o_block_valid = r_valid;
  assign o_byte_count  = r_cnt;
  assign o_overflow    = r_overflow;

endmodule

// File: tb/tb_w5500_block_assembler.sv
// Directed bench for w5500_block_assembler: full, padded, aligned, backpressure, blocked flush, reset.
module tb_w5500_block_assembler;

  logic         i_clk;
  logic         i_rst_n;
  logic [7:0]   i_data_in;
  logic         i_data_valid;
  logic         i_flush;
  logic [127:0] o_block;
  logic         o_block_valid;
  logic         i_block_ready;
  logic [4:0]   o_byte_count;
  logic         o_overflow;

  int unsigned n_checks;
  int unsigned n_fail;

  w5500_block_assembler #(
    .DATA_WIDTH  (8),
    .BLOCK_BYTES (16)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_data_in     (i_data_in),
    .i_data_valid  (i_data_valid),
    .i_flush       (i_flush),
    .o_block       (o_block),
    .o_block_valid (o_block_valid),
    .i_block_ready (i_block_ready),
    .o_byte_count  (o_byte_count),
    .o_overflow    (o_overflow)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    i_data_in    = b;
    i_data_valid = 1'b1;
    tick();
    i_data_valid = 1'b0;
  endtask

  function automatic logic [127:0] seq16(input logic [7:0] start);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < 16; i++)
      v[127-8*i -: 8] = start + 8'(i);
    return v;
  endfunction

  localparam logic [127:0] PAD_EMPTY = {16{8'h10}};

  initial begin
    n_checks = 0;
    n_fail   = 0;
    i_rst_n = 1'b0; i_data_in = '0; i_data_valid = 1'b0; i_flush = 1'b0; i_block_ready = 1'b1;
    #12;
    chk("rst_block", o_block, '0);
    chk("rst_valid", 128'(o_block_valid), 128'd0);
    chk("rst_count", 128'(o_byte_count), 128'd0);
    chk("rst_ovf",   128'(o_overflow), 128'd0);
    #11 i_rst_n = 1'b1;
    tick();

    // full block
    for (int i = 0; i < 16; i++) begin
      send(8'(i));
      if (i == 4) chk("full_cnt5", 128'(o_byte_count), 128'd5);
    end
    chk("full_valid", 128'(o_block_valid), 128'd1);
    chk("full_block", o_block, 128'h000102030405060708090A0B0C0D0E0F);
    chk("full_cnt0",  128'(o_byte_count), 128'd0);
    tick();
    chk("full_drop",  128'(o_block_valid), 128'd0);

    // partial flush
    send(8'hAA); send(8'hBB); send(8'hCC);
    i_flush = 1'b1; tick(); i_flush = 1'b0;
    chk("part_valid", 128'(o_block_valid), 128'd1);
    chk("part_block", o_block, 128'hAABBCC0D0D0D0D0D0D0D0D0D0D0D0D0D);
    tick();
    chk("part_drop", 128'(o_block_valid), 128'd0);

    // empty flush
    i_flush = 1'b1; tick(); i_flush = 1'b0;
    chk("empty_valid", 128'(o_block_valid), 128'd1);
    chk("empty_block", o_block, PAD_EMPTY);
    tick();

    // aligned flush together with the 16th byte
    for (int i = 0; i < 15; i++) send(8'h20 + 8'(i));
    i_flush = 1'b1; send(8'h2F); i_flush = 1'b0;
    chk("align_data", o_block, seq16(8'h20));
    chk("align_valid", 128'(o_block_valid), 128'd1);
    tick();
    chk("align_pad", o_block, PAD_EMPTY);
    chk("align_pad_valid", 128'(o_block_valid), 128'd1);
    tick();
    chk("align_done", 128'(o_block_valid), 128'd0);

    // backpressure and overflow
    i_block_ready = 1'b0;
    for (int i = 0; i < 33; i++) send(8'h40 + 8'(i));
    chk("bp_block", o_block, seq16(8'h40));
    chk("bp_valid", 128'(o_block_valid), 128'd1);
    chk("bp_cnt",   128'(o_byte_count), 128'd16);
    chk("bp_ovf",   128'(o_overflow), 128'd1);
    i_block_ready = 1'b1;
    tick();
    chk("bp_second", o_block, seq16(8'h50));
    chk("bp_b2b_valid", 128'(o_block_valid), 128'd1);
    chk("bp_cnt0", 128'(o_byte_count), 128'd0);
    tick();
    chk("bp_done", 128'(o_block_valid), 128'd0);
    chk("bp_ovf_sticky", 128'(o_overflow), 128'd1);

    // blocked flush
    i_block_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(8'h70 + 8'(i));
    send(8'h80); send(8'h81); send(8'h82);
    i_flush = 1'b1; tick(); i_flush = 1'b0;
    chk("blk_hold", o_block, seq16(8'h70));
    chk("blk_cnt3", 128'(o_byte_count), 128'd3);
    i_block_ready = 1'b1;
    tick();
    chk("blk_pad", o_block, 128'h8081820D0D0D0D0D0D0D0D0D0D0D0D0D);
    chk("blk_pad_valid", 128'(o_block_valid), 128'd1);
    tick();
    chk("blk_done", 128'(o_block_valid), 128'd0);
    chk("blk_cnt0", 128'(o_byte_count), 128'd0);

    // asynchronous reset mid-block
    for (int i = 0; i < 7; i++) send(8'hF0 + 8'(i));
    #3 i_rst_n = 1'b0;
    #1;
    chk("arst_block", o_block, '0);
    chk("arst_cnt",   128'(o_byte_count), 128'd0);
    chk("arst_ovf",   128'(o_overflow), 128'd0);
    chk("arst_valid", 128'(o_block_valid), 128'd0);
    #3 i_rst_n = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) send(8'h90 + 8'(i));
    chk("clean_block", o_block, seq16(8'h90));
    chk("clean_valid", 128'(o_block_valid), 128'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/w5500_block_assembler.md
# w5500_block_assembler

Byte-to-block packer between the W5500 driver's receive byte stream (`o_data_out` / `o_data_ready`) and the cipher core. It collects received bytes into 128-bit cipher blocks and pads a partial block with PKCS#7 on a flush request. It double-buffers so that reception continues while the cipher core holds off. The driver has no backpressure, so this block detects overflow, drops the excess bytes and flags the event.

## Interface
- `DATA_WIDTH`, 8: input byte width. Only 8 is supported.
- `BLOCK_BYTES`, 16: bytes per output block. The output width is `BLOCK_BYTES*DATA_WIDTH` = 128.
- `i_clk`  in  1  system clock; all logic is on the rising edge.
- `i_rst_n`  in  1  reset, asynchronous and active-low.
- `i_data_in`  in  8  received byte from the W5500 driver.
- `i_data_valid`  in  1  one-cycle strobe; `i_data_in` is valid in this cycle.
- `i_flush`  in  1  one-cycle strobe; ends the message and pads the current partial block.
- `o_block`  out  128  assembled block. The first byte received sits in [127:120].
- `o_block_valid`  out  1  `o_block` is valid. Held until it is accepted.
- `i_block_ready`  in  1  the cipher core accepts; a transfer occurs when valid && ready.
- `o_byte_count`  out  5  number of bytes currently in the assembly register (0..16).
- `o_overflow`  out  1  sticky flag: a byte was dropped. Cleared only by reset.

## Operation
- **Storage:**
  - Assembly register `asm` (128 bits) with counter `cnt`.
  - Output register `out` with `o_block_valid`.
  - One flag, `flush_pend`.
- **Byte accept:** a byte is accepted when `i_data_valid` is high and `cnt<16`. It is written at byte slot `cnt`, i.e. bits [127-8*cnt -: 8], and `cnt` then increments.
- **Byte drop:** a byte is dropped when `i_data_valid` is high and `cnt==16`. This happens only while the assembly register is full and stuck behind a full `out`. `o_overflow` is set.
- **Output-free condition:** the output register is free when `!o_block_valid`, or when `o_block_valid && i_block_ready` in the same cycle.
- **Transfer `asm` to `out`:** occurs in a cycle where the output is free and one of the following holds:
  - (a) the post-accept count equals 16 (full block), or
  - (b) `flush_pend`, or `i_flush` this cycle, is set.
  
  The `out` register and counter update on a transfer as follows:
  - **Full block:** `out` receives `asm` unchanged.
  - **Partial flush, n = post-accept count (1..15):** `out` receives the n data bytes, then slots n..15 filled with the byte value 16-n.
  - **Flush with n=0:** `out` receives sixteen bytes of 0x10, the PKCS#7 empty-final block.
  - **Flush with n=16:** `out` receives the full block. `flush_pend` stays set and then produces a following 0x10 pad block on the next free output slot, per PKCS#7.
  - **Counter after any transfer:** `cnt` becomes 0, and the slots of `asm` are don't-care.
- **Flush blocked:** if `i_flush` arrives while the output is not free, `flush_pend` is set and the flush is serviced on the first free cycle. A second `i_flush` while one is pending is absorbed, so only one pad is applied.
- **Byte and flush in the same cycle:** the byte is accepted first, and the pad length uses the post-accept count.
- **Accept during transfer:** a byte accepted in the same cycle as a full-block transfer is impossible, because `cnt` cannot exceed 16. After a transfer, the next byte lands in slot 0.
- **States (implicit in `cnt`, `o_block_valid` and `flush_pend`):**
  - EMPTY: `cnt`=0, `out` empty.
  - FILLING: 0<`cnt`<16.
  - HOLD: `cnt`=16, `out` full, bytes dropped.
  - DRAIN: `out` valid, waiting for `i_block_ready`.

## Timing
- **Reset values:** `o_block`=0, `o_block_valid`=0, `o_byte_count`=0, `o_overflow`=0, `flush_pend`=0. Reset mid-block discards all data immediately, asynchronously.
- **Latency:** when the 16th byte strobe arrives at edge N with `out` free, `o_block_valid` is high after edge N. The same one-cycle latency applies from `i_flush` to `o_block_valid`.
- **Valid/ready handshake:** `o_block` and `o_block_valid` are stable while valid && !ready. Valid drops after the accepting edge unless a new transfer reloads `out` in that same cycle, which gives back-to-back valid.
- **Throughput and output update:**
  - Sustained rate is 1 byte/cycle with no loss while `i_block_ready` stays high.
  - `o_byte_count` and `o_overflow` are registered and reflect the state after each edge.

## Test plan
- **Full block:** 16 bytes 0x00..0x0F, ready=1 → one block 0x000102…0F, valid for 1 cycle, 1 cycle after the last byte; `o_byte_count` returns to 0.
- **Partial flush:** bytes 0xAA,0xBB,0xCC then `i_flush` → block AABBCC followed by 13 bytes of 0x0D.
- **Empty flush and aligned flush:**
  - `i_flush` with `cnt`=0 → sixteen 0x10 bytes.
  - 16 bytes, then `i_flush` in the same cycle as the 16th byte → data block, then a 0x10 pad block.
- **Backpressure and overflow:** ready=0 and 33 consecutive bytes → `out` holds bytes 0–15, `asm` holds 16–31, byte 32 is dropped and `o_overflow`=1. Then ready=1 → two blocks in order, and `o_overflow` remains 1.
- **Blocked flush:** `i_flush` while `out` is full and ready=0 → no change. Raise ready → the data block is accepted, then the padded block appears on the next cycle.
- **Reset mid-block:** 7 bytes, then pulse `i_rst_n` low asynchronously (not edge-aligned) → all outputs reset to 0 immediately. The next 16 bytes produce a clean block.
